// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-reprogrammable video timing generator.
// Produces sync, data-enable, raw counters, active coordinates and line/frame
// strobes. New timing is staged in a pending register and only becomes active
// on a frame boundary (or at once while idle), so frames are never torn.
module video_timing_gen #(
   parameter int unsigned CNT_W    = 12,
   parameter int unsigned H_ACTIVE = 480,
   parameter int unsigned H_FP     = 2,
   parameter int unsigned H_SYNC   = 41,
   parameter int unsigned H_BP     = 2,
   parameter int unsigned V_ACTIVE = 272,
   parameter int unsigned V_FP     = 2,
   parameter int unsigned V_SYNC   = 10,
   parameter int unsigned V_BP     = 2,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_h_active,
   input  logic [CNT_W-1:0] cfg_h_fp,
   input  logic [CNT_W-1:0] cfg_h_sync,
   input  logic [CNT_W-1:0] cfg_h_bp,
   input  logic [CNT_W-1:0] cfg_v_active,
   input  logic [CNT_W-1:0] cfg_v_fp,
   input  logic [CNT_W-1:0] cfg_v_sync,
   input  logic [CNT_W-1:0] cfg_v_bp,
   input  logic             cfg_hs_pol,
   input  logic             cfg_vs_pol,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic [CNT_W-1:0] active_x,
   output logic [CNT_W-1:0] active_y,
   output logic             line_start,
   output logic             frame_start
);

   // Sums of four CNT_W fields need two extra bits to never overflow.
   localparam int unsigned   SW      = CNT_W + 2;
   localparam logic [SW-1:0] MAX_TOT = SW'(1) << CNT_W;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   typedef struct packed {
      logic [CNT_W-1:0] h_act;
      logic [CNT_W-1:0] h_fp;
      logic [CNT_W-1:0] h_sync;
      logic [CNT_W-1:0] h_bp;
      logic [CNT_W-1:0] v_act;
      logic [CNT_W-1:0] v_fp;
      logic [CNT_W-1:0] v_sync;
      logic [CNT_W-1:0] v_bp;
      logic             hs_pol;
      logic             vs_pol;
   } cfg_t;

   localparam cfg_t CFG_DEFAULT = '{
      h_act:  CNT_W'(H_ACTIVE), h_fp: CNT_W'(H_FP),
      h_sync: CNT_W'(H_SYNC),   h_bp: CNT_W'(H_BP),
      v_act:  CNT_W'(V_ACTIVE), v_fp: CNT_W'(V_FP),
      v_sync: CNT_W'(V_SYNC),   v_bp: CNT_W'(V_BP),
      hs_pol: HS_POL,           vs_pol: VS_POL
   };

   function automatic logic [SW-1:0] tot4(input logic [CNT_W-1:0] a, b, c, d);
      return SW'(a) + SW'(b) + SW'(c) + SW'(d);
   endfunction

   logic [0:0]       r_state;
   cfg_t             r_act;
   cfg_t             r_pend_cfg;
   logic             r_pend;
   logic             r_err;
   logic [CNT_W-1:0] r_h;
   logic [CNT_W-1:0] r_v;
   logic             r_hs;
   logic             r_vs;
   logic             r_de;
   logic [CNT_W-1:0] r_ax;
   logic [CNT_W-1:0] r_ay;
   logic             r_ls;
   logic             r_fs;

   cfg_t             w_in;
   logic [SW-1:0]    w_in_htot;
   logic [SW-1:0]    w_in_vtot;
   logic             w_in_ok;
   logic             w_capture;
   logic [SW-1:0]    w_htot;
   logic [SW-1:0]    w_vtot;
   logic             w_h_last;
   logic             w_v_last;
   logic             w_apply;
   logic [0:0]       w_state_n;
   logic [CNT_W-1:0] w_h_n;
   logic [CNT_W-1:0] w_v_n;
   logic             w_run_n;
   logic [CNT_W-1:0] w_e_hsync;
   logic [CNT_W-1:0] w_e_hbp;
   logic [CNT_W-1:0] w_e_hact;
   logic [CNT_W-1:0] w_e_vsync;
   logic [CNT_W-1:0] w_e_vbp;
   logic [CNT_W-1:0] w_e_vact;
   logic             w_e_hpol;
   logic             w_e_vpol;
   logic [SW-1:0]    w_hx;
   logic [SW-1:0]    w_vx;
   logic [SW-1:0]    w_h_lo;
   logic [SW-1:0]    w_h_hi;
   logic [SW-1:0]    w_v_lo;
   logic [SW-1:0]    w_v_hi;
   logic             w_de_n;

   // Incoming configuration and its validity check at capture time.
   assign w_in = '{
      h_act:  cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
      v_act:  cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
      hs_pol: cfg_hs_pol,   vs_pol: cfg_vs_pol
   };
   assign w_in_htot = tot4(w_in.h_sync, w_in.h_bp, w_in.h_act, w_in.h_fp);
   assign w_in_vtot = tot4(w_in.v_sync, w_in.v_bp, w_in.v_act, w_in.v_fp);
   assign w_in_ok   = (w_in.h_act != '0) && (w_in.h_sync != '0) &&
                      (w_in.v_act != '0) && (w_in.v_sync != '0) &&
                      (w_in_htot <= MAX_TOT) && (w_in_vtot <= MAX_TOT);
   assign w_capture = cfg_valid && !r_pend;
   assign cfg_ready = !r_pend;

   // Frame-end detection against the currently active timing.
   assign w_htot   = tot4(r_act.h_sync, r_act.h_bp, r_act.h_act, r_act.h_fp);
   assign w_vtot   = tot4(r_act.v_sync, r_act.v_bp, r_act.v_act, r_act.v_fp);
   assign w_h_last = (SW'(r_h) == w_htot - SW'(1));
   assign w_v_last = (SW'(r_v) == w_vtot - SW'(1));
   assign w_apply  = r_pend && ((r_state == S_IDLE) || (w_h_last && w_v_last));

   // Next state and next counter values.
   always_comb begin
      w_state_n = r_state;
      w_h_n     = '0;
      w_v_n     = '0;
      if (r_state == S_RUN) begin
         if (!en) begin
            w_state_n = S_IDLE;
         end else if (w_h_last) begin
            w_v_n = w_v_last ? '0 : r_v + CNT_W'(1);
         end else begin
            w_h_n = r_h + CNT_W'(1);
            w_v_n = r_v;
         end
      end else if (en) begin
         w_state_n = S_RUN;
      end
   end

   // Outputs are decoded from the next counters so they register in step with
   // them; the timing used is the one in force for that next cycle, which is
   // the pending set when it is being applied on this edge.
   assign w_run_n   = (w_state_n == S_RUN);
   assign w_e_hsync = w_apply ? r_pend_cfg.h_sync : r_act.h_sync;
   assign w_e_hbp   = w_apply ? r_pend_cfg.h_bp   : r_act.h_bp;
   assign w_e_hact  = w_apply ? r_pend_cfg.h_act  : r_act.h_act;
   assign w_e_vsync = w_apply ? r_pend_cfg.v_sync : r_act.v_sync;
   assign w_e_vbp   = w_apply ? r_pend_cfg.v_bp   : r_act.v_bp;
   assign w_e_vact  = w_apply ? r_pend_cfg.v_act  : r_act.v_act;
   assign w_e_hpol  = w_apply ? r_pend_cfg.hs_pol : r_act.hs_pol;
   assign w_e_vpol  = w_apply ? r_pend_cfg.vs_pol : r_act.vs_pol;

   assign w_hx   = SW'(w_h_n);
   assign w_vx   = SW'(w_v_n);
   assign w_h_lo = SW'(w_e_hsync) + SW'(w_e_hbp);
   assign w_h_hi = w_h_lo + SW'(w_e_hact);
   assign w_v_lo = SW'(w_e_vsync) + SW'(w_e_vbp);
   assign w_v_hi = w_v_lo + SW'(w_e_vact);
   assign w_de_n = w_run_n && (w_hx >= w_h_lo) && (w_hx < w_h_hi) &&
                   (w_vx >= w_v_lo) && (w_vx < w_v_hi);

   // Active/pending configuration registers and the capture handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_act      <= CFG_DEFAULT;
         r_pend_cfg <= CFG_DEFAULT;
         r_pend     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act  <= r_pend_cfg;
            r_pend <= 1'b0;
         end
         if (w_capture && w_in_ok) begin
            r_pend_cfg <= w_in;
            r_pend     <= 1'b1;
         end
         r_err <= w_capture && !w_in_ok;
      end
   end

   // Run/idle state, counters and registered timing outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_hs    <= ~HS_POL;
         r_vs    <= ~VS_POL;
         r_de    <= 1'b0;
         r_ax    <= '0;
         r_ay    <= '0;
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_h     <= w_h_n;
         r_v     <= w_v_n;
         r_hs    <= (w_run_n && (w_hx < SW'(w_e_hsync))) ? w_e_hpol : ~w_e_hpol;
         r_vs    <= (w_run_n && (w_vx < SW'(w_e_vsync))) ? w_e_vpol : ~w_e_vpol;
         r_de    <= w_de_n;
         r_ax    <= w_de_n ? CNT_W'(w_hx - w_h_lo) : '0;
         r_ay    <= w_de_n ? CNT_W'(w_vx - w_v_lo) : '0;
         r_ls    <= w_run_n && (w_h_n == '0);
         r_fs    <= w_run_n && (w_h_n == '0) && (w_v_n == '0);
      end
   end

   assign cfg_err     = r_err;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign de          = r_de;
   assign h_cnt       = r_h;
   assign v_cnt       = r_v;
   assign active_x    = r_ax;
   assign active_y    = r_ay;
   assign line_start  = r_ls;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a small timing (H 2/1/4/1, V 1/1/3/1).
module tb_video_timing_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [11:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
   logic [11:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
   logic        cfg_hs_pol, cfg_vs_pol, cfg_valid;
   logic        cfg_ready, cfg_err, hs, vs, de, line_start, frame_start;
   logic [11:0] h_cnt, v_cnt, active_x, active_y;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   string step = "init";

   // Reference state: run flag, counters, active/pending timing (ha,hf,hs,hb,va,vf,vs,vb).
   logic m_run, m_pend, m_err, m_hp, m_vp, m_php, m_pvp;
   int   eh, ev;
   int   m_c[8];
   int   m_pc[8];

   video_timing_gen #(
      .CNT_W(12),
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp),
      .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
      .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
      .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
      .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .hs(hs), .vs(vs), .de(de),
      .h_cnt(h_cnt), .v_cnt(v_cnt),
      .active_x(active_x), .active_y(active_y),
      .line_start(line_start), .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      eh     = 0;
      ev     = 0;
      m_c    = '{4, 1, 2, 1, 3, 1, 1, 1};
      m_hp   = 1'b1;
      m_vp   = 1'b1;
   endtask

   function automatic logic [54:0] model_out();
      logic e_hs, e_vs, e_de;
      int   hlo, vlo;
      logic [11:0] ax, ay, hh, vv;
      if (!m_run)
         return {~m_hp, ~m_vp, 3'b000, ~m_pend, m_err, 48'd0};
      hlo  = m_c[2] + m_c[3];
      vlo  = m_c[6] + m_c[7];
      e_hs = (eh < m_c[2]) ? m_hp : ~m_hp;
      e_vs = (ev < m_c[6]) ? m_vp : ~m_vp;
      e_de = (eh >= hlo) && (eh < hlo + m_c[0]) && (ev >= vlo) && (ev < vlo + m_c[4]);
      ax   = e_de ? 12'(eh - hlo) : 12'd0;
      ay   = e_de ? 12'(ev - vlo) : 12'd0;
      hh   = 12'(eh);
      vv   = 12'(ev);
      return {e_hs, e_vs, e_de, (eh == 0), (eh == 0 && ev == 0), ~m_pend, m_err,
              hh, vv, ax, ay};
   endfunction

   // Advance the reference by one clock, clock the DUT, compare every output.
   task automatic tick();
      logic cap, apply, ok;
      int htot, vtot, nh, nv;
      logic [54:0] obs, exp;
      cap  = cfg_valid && !m_pend;
      htot = m_c[0] + m_c[1] + m_c[2] + m_c[3];
      vtot = m_c[4] + m_c[5] + m_c[6] + m_c[7];
      if (rst) begin
         model_reset();
      end else begin
         apply = m_pend && (!m_run || (eh == htot - 1 && ev == vtot - 1));
         if (m_run && !en) begin
            m_run = 1'b0; eh = 0; ev = 0;
         end else if (!m_run && en) begin
            m_run = 1'b1; eh = 0; ev = 0;
         end else if (m_run) begin
            if (eh == htot - 1) begin
               eh = 0;
               ev = (ev == vtot - 1) ? 0 : ev + 1;
            end else begin
               eh = eh + 1;
            end
         end
         if (apply) begin
            m_c = m_pc; m_hp = m_php; m_vp = m_pvp; m_pend = 1'b0;
         end
         m_err = 1'b0;
         if (cap) begin
            nh = int'(cfg_h_active) + int'(cfg_h_fp) + int'(cfg_h_sync) + int'(cfg_h_bp);
            nv = int'(cfg_v_active) + int'(cfg_v_fp) + int'(cfg_v_sync) + int'(cfg_v_bp);
            ok = (cfg_h_active != 0) && (cfg_h_sync != 0) && (cfg_v_active != 0) &&
                 (cfg_v_sync != 0) && (nh <= 4096) && (nv <= 4096);
            if (ok) begin
               m_pc = '{int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
                        int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp)};
               m_php  = cfg_hs_pol;
               m_pvp  = cfg_vs_pol;
               m_pend = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      obs = {hs, vs, de, line_start, frame_start, cfg_ready, cfg_err,
             h_cnt, v_cnt, active_x, active_y};
      exp = model_out();
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d outputs: got=%h want=%h", step, cyc, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s/%s: got=%0h want=%0h", step, tag, got, want);
      end
   endtask

   task automatic set_cfg(input int ha, hf, hsy, hb, va, vf, vsy, vb,
                          input logic hp, vp);
      cfg_h_active = 12'(ha); cfg_h_fp = 12'(hf); cfg_h_sync = 12'(hsy); cfg_h_bp = 12'(hb);
      cfg_v_active = 12'(va); cfg_v_fp = 12'(vf); cfg_v_sync = 12'(vsy); cfg_v_bp = 12'(vb);
      cfg_hs_pol   = hp;
      cfg_vs_pol   = vp;
      cfg_valid    = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      model_reset();

      // Reset values during rst and one idle cycle after.
      step = "reset";
      tick(); tick();
      chk("h", 32'(h_cnt), 0);       chk("v", 32'(v_cnt), 0);
      chk("hs", 32'(hs), 0);         chk("vs", 32'(vs), 0);
      chk("de", 32'(de), 0);         chk("fs", 32'(frame_start), 0);
      chk("ls", 32'(line_start), 0); chk("ax", 32'(active_x), 0);
      chk("rdy", 32'(cfg_ready), 1); chk("err", 32'(cfg_err), 0);
      rst = 1'b0;
      tick();
      chk("idle_h", 32'(h_cnt), 0); chk("idle_hs", 32'(hs), 0); chk("idle_ls", 32'(line_start), 0);

      // First frame with parameter timing: 8 x 6 = 48 cycles.
      step = "frame0";
      en = 1'b1;
      tick();
      chk("h", 32'(h_cnt), 0); chk("v", 32'(v_cnt), 0);
      chk("hs", 32'(hs), 1);   chk("vs", 32'(vs), 1);
      chk("ls", 32'(line_start), 1); chk("fs", 32'(frame_start), 1);
      chk("de", 32'(de), 0);
      repeat (19) tick();
      chk("h19", 32'(h_cnt), 3); chk("v19", 32'(v_cnt), 2);
      chk("de19", 32'(de), 1);   chk("ax19", 32'(active_x), 0); chk("ay19", 32'(active_y), 0);
      repeat (28) tick();
      chk("h47", 32'(h_cnt), 7); chk("v47", 32'(v_cnt), 5); chk("fs47", 32'(frame_start), 0);
      tick();
      chk("fs48", 32'(frame_start), 1); chk("h48", 32'(h_cnt), 0);

      // Mid-frame reconfiguration to H_ACTIVE=6 (line total 10).
      step = "midcfg";
      repeat (16) tick();
      set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("rdy_lo", 32'(cfg_ready), 0); chk("h_old", 32'(h_cnt), 1); chk("v_old", 32'(v_cnt), 2);
      repeat (30) tick();
      chk("last_h", 32'(h_cnt), 7); chk("last_rdy", 32'(cfg_ready), 0);
      tick();
      chk("new_rdy", 32'(cfg_ready), 1); chk("new_fs", 32'(frame_start), 1);
      repeat (9) tick();
      chk("h9", 32'(h_cnt), 9); chk("v9", 32'(v_cnt), 0);
      repeat (19) tick();
      chk("h28", 32'(h_cnt), 8); chk("de28", 32'(de), 1); chk("ax28", 32'(active_x), 5);
      repeat (32) tick();
      chk("fs60", 32'(frame_start), 1); chk("v60", 32'(v_cnt), 0);

      // Rejected config (h_sync = 0): one error pulse, timing unchanged.
      step = "reject";
      set_cfg(4, 1, 0, 1, 3, 1, 1, 1, 1'b0, 1'b0);
      tick();
      cfg_valid = 1'b0;
      chk("err1", 32'(cfg_err), 1); chk("rdy1", 32'(cfg_ready), 1);
      tick();
      chk("err0", 32'(cfg_err), 0);
      repeat (7) tick();
      chk("h9", 32'(h_cnt), 9); chk("hs_pol", 32'(hs), 0);
      repeat (111) tick();
      chk("fs120", 32'(frame_start), 1); chk("h120", 32'(h_cnt), 0);

      // Drop enable mid-frame, then restart.
      step = "endrop";
      repeat (35) tick();
      chk("h", 32'(h_cnt), 5); chk("v", 32'(v_cnt), 3);
      chk("ax", 32'(active_x), 2); chk("ay", 32'(active_y), 1);
      en = 1'b0;
      tick();
      chk("idle_h", 32'(h_cnt), 0); chk("idle_v", 32'(v_cnt), 0);
      chk("idle_hs", 32'(hs), 0);   chk("idle_de", 32'(de), 0);
      tick(); tick();
      en = 1'b1;
      tick();
      chk("re_fs", 32'(frame_start), 1); chk("re_hs", 32'(hs), 1); chk("re_h", 32'(h_cnt), 0);

      // Reset while a config is pending: parameter timing returns.
      step = "rstpend";
      repeat (10) tick();
      set_cfg(3, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("rdy_lo", 32'(cfg_ready), 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("rdy", 32'(cfg_ready), 1); chk("h", 32'(h_cnt), 0); chk("hs", 32'(hs), 0);
      rst = 1'b0;
      tick();
      chk("fs", 32'(frame_start), 1);
      repeat (8) tick();
      chk("h8", 32'(h_cnt), 0); chk("v8", 32'(v_cnt), 1);
      repeat (39) tick();
      tick();
      chk("fs48", 32'(frame_start), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
